// File: rtl/nbit_4ch_rr_arbiter.sv
// Four-source arbiter with a registered valid/ready output stage. By default it is round-robin.
// Defining ARB_FIXED_PRIO_EN gives fixed priority A > B > C > D and removes the pointer register.
module nbit_4ch_rr_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic [n-1:0] C,
  input  logic [n-1:0] D,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  output logic [1:0]   S,
  output logic [n-1:0] Y,
  output logic         Y_valid,
  input  logic         Y_ready
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [n-1:0] y_q, y_d;
  logic [1:0]   s_q, s_d;
  logic [1:0]   last_s;
  logic [1:0]   grant_s;
  logic         any_req_s;
  logic         load_s;

  // Scan the four sources starting just after 'last' and wrapping around. Return the first source that is requesting.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // A fixed "last" of 3 makes every search begin at source A.
  assign last_s = 2'b11;
`else
  logic [1:0] ptr_q, ptr_d;

  assign last_s = ptr_q;
  assign ptr_d  = load_s ? grant_s : ptr_q;

  // Last-grant pointer. It resets to 3 so that source A wins first.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= 2'b11;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign any_req_s = |req;
  // nrst gates the load so that ack falls immediately while reset is asserted.
  assign load_s    = nrst & any_req_s & ((state_q == EMPTY) | Y_ready);
  assign grant_s   = rr_pick(req, last_s);

  // Next-state logic, accept strobe and capture mux
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    s_d     = s_q;
    ack     = 4'b0000;
    if (load_s) begin
      ack     = 4'b0001 << grant_s;
      s_d     = grant_s;
      state_d = FULL;
      case (grant_s)
        2'd0:    y_d = A;
        2'd1:    y_d = B;
        2'd2:    y_d = C;
        2'd3:    y_d = D;
        default: y_d = y_q;
      endcase
    end else if ((state_q == FULL) && Y_ready) begin
      state_d = EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= EMPTY;
      y_q     <= '0;
      s_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      s_q     <= s_d;
    end
  end

  assign Y       = y_q;
  assign S       = s_q;
  assign Y_valid = (state_q == FULL);

endmodule

// File: tb/tb_nbit_4ch_rr_arbiter.sv
// Self-checking bench for nbit_4ch_rr_arbiter. It runs directed scenarios and then random traffic.
// The random traffic is compared against a behavioural model of the arbitration rules.
module tb_nbit_4ch_rr_arbiter;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         nrst;
  logic [N-1:0] A, B, C, D;
  logic [3:0]   req;
  logic [3:0]   ack;
  logic [1:0]   S;
  logic [N-1:0] Y;
  logic         Y_valid;
  logic         Y_ready;

  int total = 0;
  int bad   = 0;

  nbit_4ch_rr_arbiter #(.n(N)) dut (
    .clk(clk), .nrst(nrst), .A(A), .B(B), .C(C), .D(D), .req(req),
    .ack(ack), .S(S), .Y(Y), .Y_valid(Y_valid), .Y_ready(Y_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0; req = 4'b0000; Y_ready = 1'b0;
    A = '0; B = '0; C = '0; D = '0;
    #7;
    nrst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nrst = 1'b0; req = 4'b1111; Y_ready = 1'b1;
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44;
    #3;
    total++; if (Y !== 8'h00) begin bad++; $display("FAIL reset_Y got=%h want=00", Y); end
    total++; if (S !== 2'b00) begin bad++; $display("FAIL reset_S got=%b want=00", S); end
    total++; if (Y_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", Y_valid); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", ack); end
    do_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    req = 4'b0001; A = 8'h3C; Y_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL load_ack got=%b want=0001", ack); end
    step();
    req = 4'b0000;
    total++; if (Y !== 8'h3C || S !== 2'b00 || Y_valid !== 1'b1)
      begin bad++; $display("FAIL load_out got Y=%h S=%b v=%b want 3C 00 1", Y, S, Y_valid); end
    step();
    total++; if (Y_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", Y_valid); end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_y [5];
    exp_y = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    do_reset();
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44; req = 4'b1111; Y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ack !== (4'b0001 << (i % 4)))
        begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i, ack, 4'b0001 << (i % 4)); end
      step();
      total++; if (Y !== exp_y[i] || S !== 2'(i % 4))
        begin bad++; $display("FAIL rr_out[%0d] got Y=%h S=%0d want Y=%h S=%0d", i, Y, S, exp_y[i], i % 4); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44; req = 4'b0010; Y_ready = 1'b1;
    step();
    req = 4'b1101; Y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ack !== 4'b0000) begin bad++; $display("FAIL stall_ack[%0d] got=%b want=0000", i, ack); end
      step();
      total++; if (Y !== 8'h22 || S !== 2'b01 || Y_valid !== 1'b1)
        begin bad++; $display("FAIL stall_hold[%0d] got Y=%h S=%b v=%b want 22 01 1", i, Y, S, Y_valid); end
    end
    Y_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL stall_release_ack got=%b want=0100", ack); end
    step();
    total++; if (Y !== 8'h33 || S !== 2'b10)
      begin bad++; $display("FAIL stall_release_out got Y=%h S=%b want 33 10", Y, S); end
  endtask

  task automatic test_single_requester();
    do_reset();
    D = 8'hA5; req = 4'b1000; Y_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (Y !== 8'hA5 || S !== 2'b11 || Y_valid !== 1'b1)
        begin bad++; $display("FAIL single[%0d] got Y=%h S=%b v=%b want A5 11 1", i, Y, S, Y_valid); end
    end
    req = 4'b0000;
    step();
    total++; if (Y_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", Y_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44; req = 4'b1111; Y_ready = 1'b1;
    step(); step();
    #1;
    nrst = 1'b0;
    #1;
    total++; if (Y_valid !== 1'b0 || Y !== 8'h00 || S !== 2'b00 || ack !== 4'b0000)
      begin bad++; $display("FAIL areset got v=%b Y=%h S=%b ack=%b want 0 00 00 0000", Y_valid, Y, S, ack); end
    nrst = 1'b1;
    #1;
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL areset_first_ack got=%b want=0001", ack); end
    step();
    total++; if (Y !== 8'h11 || S !== 2'b00)
      begin bad++; $display("FAIL areset_first_out got Y=%h S=%b want 11 00", Y, S); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    A = 8'h11; B = 8'h22; C = 8'h33; D = 8'h44; req = 4'b1111; Y_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL fixed_ack[%0d] got=%b want=0001", i, ack); end
      step();
      total++; if (Y !== 8'h11) begin bad++; $display("FAIL fixed_Y[%0d] got=%h want=11", i, Y); end
    end
  endtask

  // Random traffic. The model is written directly from the arbitration rules.
  task automatic test_random();
    int         m_last;
    bit         m_valid;
    logic [7:0] m_y;
    int         m_s;
    logic [7:0] data [4];
    bit         ld;
    int         g;
    logic [3:0] exp_ack;
    do_reset();
    m_last = 3; m_valid = 1'b0; m_y = 8'h00; m_s = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      Y_ready = ($urandom_range(0, 3) != 0);
      A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
      data = '{A, B, C, D};
      ld = (req != 4'b0000) && (!m_valid || Y_ready);
      g = -1;
      for (int k = 1; k <= 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
        if (g < 0 && req[k - 1]) g = k - 1;
`else
        if (g < 0 && req[(m_last + k) % 4]) g = (m_last + k) % 4;
`endif
      end
      exp_ack = ld ? (4'b0001 << g) : 4'b0000;
      #1;
      total++; if (ack !== exp_ack)
        begin bad++; $display("FAIL rand_ack[%0d] got=%b want=%b", cyc, ack, exp_ack); end
      step();
      if (ld) begin
        m_y = data[g]; m_s = g; m_valid = 1'b1; m_last = g;
      end else if (Y_ready) begin
        m_valid = 1'b0;
      end
      total++; if (Y_valid !== m_valid || Y !== m_y || S !== 2'(m_s))
        begin bad++; $display("FAIL rand_out[%0d] got v=%b Y=%h S=%0d want v=%b Y=%h S=%0d",
                              cyc, Y_valid, Y, S, m_valid, m_y, m_s); end
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
`ifdef ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_fairness();
    test_stall();
`endif
    test_single_requester();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nbit_4ch_rr_arbiter.md
Name: nbit_4ch_rr_arbiter

Overview:
- Upstream select-and-capture stage for the team's n-bit 4:1 multiplexer datapath.
- Arbitrates four requesting sources (A–D) round-robin and drives the 2-bit select (S) of the downstream 4:1 mux.
- Registers the chosen word and presents it on a valid/ready output port, so one word per cycle moves from four producers to one consumer.

Parameters:
- n, 4, data width of each source and of Y.

Ports:
- clk  input  1  rising-edge clock.
- nrst  input  1  asynchronous active-low reset.
- A  input  n  source 0 data; must be stable while req[0]=1 and ack[0]=0.
- B  input  n  source 1 data.
- C  input  n  source 2 data.
- D  input  n  source 3 data.
- req  input  4  per-source request; bit i = source i has a word.
- ack  output  4  one-hot combinational accept; ack[i]=1 in the cycle source i's word is captured.
- S  output  2  registered index of the word held in Y; drives the downstream mux select.
- Y  output  n  registered output word.
- Y_valid  output  1  Y holds an unconsumed word.
- Y_ready  input  1  consumer accepts Y this cycle when Y_valid=1.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (nrst).
- Reset values: Y=0, S=2'b00, Y_valid=0, ack=4'b0000, last-grant pointer=2'b11, so source A has first priority after reset.
- State machine, two states:
  - EMPTY: Y_valid=0.
  - FULL: Y_valid=1.
  - EMPTY → FULL when |req.
  - FULL → EMPTY when Y_ready && !(|req).
  - FULL stays FULL when Y_ready && |req (back-to-back reload).
  - FULL stays FULL when !Y_ready; Y and S are held and ack=0.
- Load condition: load = (|req) && (!Y_valid || Y_ready).
- Grant selection is combinational on req and the pointer:
  - Search order starts at pointer+1 (mod 4) and wraps 3→0.
  - The first set req bit is granted; grant index g.
- In a load cycle:
  - ack = one-hot(g).
  - On the clock edge: Y <= selected source data (A/B/C/D for g=0..3), S <= g, Y_valid <= 1, pointer <= g.
  - ack is 0 in every non-load cycle.
- Latency: req asserted with the block EMPTY → word on Y with Y_valid=1 at the next rising edge (1 cycle).
- Throughput: 1 word/cycle while Y_ready=1 and any req stays high.
- Fairness: with all four req held high, grants cycle 0,1,2,3,0…; no source waits more than 3 grants.
- Single requester: the same source is granted every load cycle; the pointer remains equal to it.
- Pointer update: the pointer changes only on a load, never on idle cycles.
- Producer protocol:
  - A source keeps req[i] high and its data stable until it sees ack[i].
  - Dropping req before ack is allowed; that word is simply not taken.
- Y_ready while Y_valid=0 is ignored.
- Async reset mid-operation: all state returns to reset values immediately; any held word is discarded; ack drops combinationally.
- No X propagation: S and Y change only on load or reset.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority A > B > C > D. The search always starts at index 0, the pointer register is removed, and all other handshake and timing rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then n=8, req=4'b0001, A=8'h3C, Y_ready=1 → ack=0001 in cycle 0; cycle 1: Y=8'h3C, S=00, Y_valid=1.
2. req=4'b1111 held, A..D=8'h11/22/33/44, Y_ready=1 → Y sequence 11,22,33,44,11 on consecutive cycles; S sequence 00,01,10,11,00.
3. Y full with 8'h22 (S=01), Y_ready=0 for 3 cycles, req=4'b1101 → Y, S held, ack=0000; on Y_ready=1, ack=0100 and next Y=C's word with S=10.
4. Only req[3] high, D=8'hA5, Y_ready=1 for 4 cycles → Y=A5 and S=11 every cycle, Y_valid stays 1; req drops with Y_ready=1 → Y_valid=0 next cycle.
5. nrst pulsed low while FULL with req=4'b1111 → Y_valid=0, Y=0, S=00, ack=0000 during reset; first grant after release is source A (ack=0001).
6. ARB_FIXED_PRIO_EN defined, req=4'b1111, Y_ready=1 → ack=0001 every load cycle, Y always A's word.
